// File: rtl/vx_priority_iterator.sv
// vx_priority_iterator: drains an N-bit request mask over one or more beats,
// emitting up to M set-bit indices per beat in priority order.
module vx_priority_iterator #(
   parameter int N = 4,
   parameter int M = 1,
   parameter int REVERSE = 0,
   parameter int LN = (N > 1) ? $clog2(N) : 1,
   parameter int LM = $clog2(M + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic [N-1:0]    data_in,
   output logic            ready_in,
   output logic            valid_out,
   output logic [M*LN-1:0] index_out,
   output logic [M-1:0]    lane_mask,
   output logic [LM-1:0]   count_out,
   output logic            last_out,
   input  logic            ready_out
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [N-1:0] pend, pend_d, rem, pick;
   logic [LN-1:0] sel;
   logic found, last;
   // M-deep cascade of priority picks; each pick clears its bit for the next lane
   always_comb begin
      rem = pend;
      index_out = '0;
      lane_mask = '0;
      count_out = '0;
      found = 1'b0;
      sel = '0;
      pick = '0;
      for (int k = 0; k < M; k++) begin
         found = 1'b0;
         sel = '0;
         pick = '0;
         for (int i = 0; i < N; i++) begin
            if (!found && rem[(REVERSE != 0) ? N - 1 - i : i]) begin
               found = 1'b1;
               sel = LN'((REVERSE != 0) ? N - 1 - i : i);
               pick[(REVERSE != 0) ? N - 1 - i : i] = 1'b1;
            end
         end
         rem = rem & ~pick;
         index_out[k*LN +: LN] = sel;
         lane_mask[k] = found;
         count_out = count_out + LM'(found);
      end
      last = (rem == '0);
   end
   always_comb begin
      valid_out = (state_q == BUSY);
      last_out = valid_out && last;
      ready_in = !valid_out || (ready_out && last_out);
      state_d = state_q;
      pend_d = pend;
      if (valid_in && ready_in) begin
         state_d = BUSY;
         pend_d = data_in;
      end else if (valid_out && ready_out) begin
         state_d = last ? IDLE : BUSY;
         pend_d = last ? '0 : rem;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pend <= '0;
      end else begin
         state_q <= state_d;
         pend <= pend_d;
      end
   end
endmodule

// File: tb/tb_vx_priority_iterator.sv
// tb_vx_priority_iterator: directed checks of drain order, multi-lane beats,
// zero/full masks, backpressure, back-to-back masks and reset mid-drain.
module tb_vx_priority_iterator;
   logic clk = 1'b0;
   logic reset;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;

   logic a_vi, a_ri, a_vo, a_last, a_ro;
   logic [7:0] a_d;
   logic [2:0] a_idx;
   logic [0:0] a_lm, a_cnt;
   vx_priority_iterator #(.N(8), .M(1), .REVERSE(0)) u_a (
      .clk(clk), .reset(reset), .valid_in(a_vi), .data_in(a_d), .ready_in(a_ri),
      .valid_out(a_vo), .index_out(a_idx), .lane_mask(a_lm), .count_out(a_cnt),
      .last_out(a_last), .ready_out(a_ro));

   logic b_vi, b_ri, b_vo, b_last, b_ro;
   logic [7:0] b_d;
   logic [8:0] b_idx;
   logic [2:0] b_lm;
   logic [1:0] b_cnt;
   vx_priority_iterator #(.N(8), .M(3), .REVERSE(1)) u_b (
      .clk(clk), .reset(reset), .valid_in(b_vi), .data_in(b_d), .ready_in(b_ri),
      .valid_out(b_vo), .index_out(b_idx), .lane_mask(b_lm), .count_out(b_cnt),
      .last_out(b_last), .ready_out(b_ro));

   logic c_vi, c_ri, c_vo, c_last, c_ro;
   logic [3:0] c_d, c_idx;
   logic [1:0] c_lm, c_cnt;
   vx_priority_iterator #(.N(4), .M(2), .REVERSE(0)) u_c (
      .clk(clk), .reset(reset), .valid_in(c_vi), .data_in(c_d), .ready_in(c_ri),
      .valid_out(c_vo), .index_out(c_idx), .lane_mask(c_lm), .count_out(c_cnt),
      .last_out(c_last), .ready_out(c_ro));

   logic d_vi, d_ri, d_vo, d_last, d_ro;
   logic [7:0] d_d;
   logic [5:0] d_idx;
   logic [1:0] d_lm, d_cnt;
   vx_priority_iterator #(.N(8), .M(2), .REVERSE(0)) u_d (
      .clk(clk), .reset(reset), .valid_in(d_vi), .data_in(d_d), .ready_in(d_ri),
      .valid_out(d_vo), .index_out(d_idx), .lane_mask(d_lm), .count_out(d_cnt),
      .last_out(d_last), .ready_out(d_ro));

   logic e_vi, e_ri, e_vo, e_last, e_ro;
   logic [15:0] e_d;
   logic [3:0] e_idx;
   logic [0:0] e_lm, e_cnt;
   vx_priority_iterator #(.N(16), .M(1), .REVERSE(0)) u_e (
      .clk(clk), .reset(reset), .valid_in(e_vi), .data_in(e_d), .ready_in(e_ri),
      .valid_out(e_vo), .index_out(e_idx), .lane_mask(e_lm), .count_out(e_cnt),
      .last_out(e_last), .ready_out(e_ro));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      {a_vi, b_vi, c_vi, d_vi, e_vi} = '0;
      {a_d, b_d, c_d, d_d, e_d} = '0;
      {a_ro, b_ro, c_ro, d_ro, e_ro} = '1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_valid", 32'(a_vo), 0);
      chk("rst_ready", 32'(a_ri), 1);
      chk("rst_lmask", 32'(a_lm), 0);
      chk("rst_count", 32'(a_cnt), 0);
      chk("rst_index", 32'(a_idx), 0);
      chk("rst_last", 32'(a_last), 0);
      chk("rst_b_lmask", 32'(b_lm), 0);
      // basic drain, lowest index first
      a_vi = 1'b1; a_d = 8'hA6;
      tick();
      a_vi = 1'b0;
      chk("a1_valid", 32'(a_vo), 1);
      chk("a1_index", 32'(a_idx), 1);
      chk("a1_last", 32'(a_last), 0);
      chk("a1_ready", 32'(a_ri), 0);
      tick();
      chk("a2_index", 32'(a_idx), 2);
      chk("a2_last", 32'(a_last), 0);
      tick();
      chk("a3_index", 32'(a_idx), 5);
      tick();
      chk("a4_index", 32'(a_idx), 7);
      chk("a4_last", 32'(a_last), 1);
      chk("a4_ready", 32'(a_ri), 1);
      chk("a4_lmask", 32'(a_lm), 1);
      tick();
      chk("a5_valid", 32'(a_vo), 0);
      chk("a5_ready", 32'(a_ri), 1);
      // back-to-back masks
      a_vi = 1'b1; a_d = 8'h81;
      tick();
      a_d = 8'h10;
      chk("bb1_index", 32'(a_idx), 0);
      chk("bb1_last", 32'(a_last), 0);
      chk("bb1_ready", 32'(a_ri), 0);
      tick();
      chk("bb2_index", 32'(a_idx), 7);
      chk("bb2_last", 32'(a_last), 1);
      chk("bb2_ready", 32'(a_ri), 1);
      tick();
      a_vi = 1'b0;
      chk("bb3_valid", 32'(a_vo), 1);
      chk("bb3_index", 32'(a_idx), 4);
      chk("bb3_last", 32'(a_last), 1);
      tick();
      chk("bb4_valid", 32'(a_vo), 0);
      // multi-lane reverse
      b_vi = 1'b1; b_d = 8'hB5;
      tick();
      b_vi = 1'b0;
      chk("b1_index", 32'(b_idx), 32'h12F);
      chk("b1_lmask", 32'(b_lm), 7);
      chk("b1_count", 32'(b_cnt), 3);
      chk("b1_last", 32'(b_last), 0);
      tick();
      chk("b2_index", 32'(b_idx), 2);
      chk("b2_lmask", 32'(b_lm), 3);
      chk("b2_count", 32'(b_cnt), 2);
      chk("b2_last", 32'(b_last), 1);
      tick();
      chk("b3_valid", 32'(b_vo), 0);
      // zero mask, then full mask
      c_vi = 1'b1; c_d = 4'h0;
      tick();
      c_vi = 1'b0;
      chk("c0_valid", 32'(c_vo), 1);
      chk("c0_lmask", 32'(c_lm), 0);
      chk("c0_count", 32'(c_cnt), 0);
      chk("c0_last", 32'(c_last), 1);
      tick();
      chk("c0_done", 32'(c_vo), 0);
      c_vi = 1'b1; c_d = 4'hF;
      tick();
      c_vi = 1'b0;
      chk("cf1_index", 32'(c_idx), 32'h4);
      chk("cf1_lmask", 32'(c_lm), 3);
      chk("cf1_last", 32'(c_last), 0);
      tick();
      chk("cf2_index", 32'(c_idx), 32'hE);
      chk("cf2_count", 32'(c_cnt), 2);
      chk("cf2_last", 32'(c_last), 1);
      tick();
      chk("cf3_valid", 32'(c_vo), 0);
      // backpressure with ready_out 1,0,0,1
      d_ro = 1'b0; d_vi = 1'b1; d_d = 8'hFF;
      tick();
      d_vi = 1'b0;
      chk("d1_index", 32'(d_idx), 32'h08);
      chk("d1_valid", 32'(d_vo), 1);
      d_ro = 1'b1;
      tick();
      chk("d2_index", 32'(d_idx), 32'h1A);
      d_ro = 1'b0;
      tick();
      chk("d2_stall1", 32'(d_idx), 32'h1A);
      chk("d2_stall1_v", 32'(d_vo), 1);
      chk("d2_stall1_ri", 32'(d_ri), 0);
      tick();
      chk("d2_stall2", 32'(d_idx), 32'h1A);
      chk("d2_stall2_lm", 32'(d_lm), 3);
      d_ro = 1'b1;
      tick();
      chk("d3_index", 32'(d_idx), 32'h2C);
      chk("d3_last", 32'(d_last), 0);
      tick();
      chk("d4_index", 32'(d_idx), 32'h3E);
      chk("d4_last", 32'(d_last), 1);
      tick();
      chk("d5_valid", 32'(d_vo), 0);
      // reset mid-drain
      e_vi = 1'b1; e_d = 16'hFFFF;
      tick();
      e_vi = 1'b0;
      chk("e1_index", 32'(e_idx), 0);
      tick();
      chk("e2_index", 32'(e_idx), 1);
      tick();
      chk("e3_index", 32'(e_idx), 2);
      tick();
      chk("e4_index", 32'(e_idx), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("er_valid", 32'(e_vo), 0);
      chk("er_ready", 32'(e_ri), 1);
      chk("er_index", 32'(e_idx), 0);
      chk("er_lmask", 32'(e_lm), 0);
      chk("er_last", 32'(e_last), 0);
      e_vi = 1'b1; e_d = 16'h0002;
      tick();
      e_vi = 1'b0;
      chk("en_valid", 32'(e_vo), 1);
      chk("en_index", 32'(e_idx), 1);
      chk("en_last", 32'(e_last), 1);
      chk("en_count", 32'(e_cnt), 1);
      tick();
      chk("en_done", 32'(e_vo), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vx_priority_iterator.md
# VX_priority_iterator

Sequential, multi-lane successor to the single-pick priority encoder. Accepts an N-bit request mask through a valid/ready handshake and drains it over one or more output beats. Each beat emits the next M set bits in priority order as M index lanes, with a lane-valid mask and a last-beat flag. Sits between warp/thread schedulers and dispatch stages that must visit every active thread or bank in a mask, not just the first one.

## Interface
- N, 4: request mask width; N >= 1.
- M, 1: index lanes per output beat; 1 <= M <= N.
- REVERSE, 0: 0 = lowest set index has priority; 1 = highest set index has priority.
- LN, `LOG2UP(N)`: index width (derived).
- LM, `CLOG2(M+1)`: lane-count width (derived).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  request mask valid.
- data_in  in  N  request mask.
- ready_in  out  1  block can accept a mask this cycle.
- valid_out  out  1  output beat valid.
- index_out  out  M*LN  lane k index in bits [k*LN +: LN]; lane 0 has the highest priority.
- lane_mask  out  M  bit k set when lane k carries a valid index.
- count_out  out  LM  popcount(lane_mask).
- last_out  out  1  this beat exhausts the mask.
- ready_out  in  1  consumer accepts the beat.

## Operation
- State: pending mask register `pend[N-1:0]` and a 1-bit state, IDLE or BUSY.
- Reset values: IDLE, pend = 0, valid_out = 0, ready_in = 1, lane_mask = 0, count_out = 0, index_out = 0, last_out = 0.
- Accept: a mask is accepted when valid_in && ready_in. On accept, pend <= data_in and the block enters BUSY.
- ready_in = IDLE || (valid_out && ready_out && last_out). This allows back-to-back masks with no bubble cycle.
- valid_out = BUSY.
- Beat contents are computed combinationally from pend only, never from data_in:
  - Lane k is the k-th set bit of pend in priority order.
  - The lane_mask bits that are set are always contiguous from lane 0.
  - Unused lanes have index 0 and lane_mask bit 0.
- last_out = 1 when popcount(pend) <= M.
- Zero mask: accepting data_in = 0 still produces exactly one beat with lane_mask = 0, count_out = 0 and last_out = 1, so the consumer always sees a completion.
- On beat handshake (valid_out && ready_out):
  - Without last_out: pend <= pend & ~(onehot of every emitted index); stay BUSY.
  - With last_out and a simultaneous accept: pend <= data_in; stay BUSY.
  - With last_out and no accept: go IDLE, pend <= 0.
- Stall: while valid_out && !ready_out, pend and every output stay stable.
- valid_in while BUSY and not on the last beat is not accepted. The producer holds its mask until ready_in is asserted.
- Reset mid-drain: the remaining bits are discarded and all outputs return to their reset values in the next cycle.
- N == 1: degenerate case. Lane 0 index is 0; the beat is valid with lane_mask = pend[0].

## Timing
- Latency from accept to first valid_out is 1 cycle (registered pend).
- Beats per mask = max(1, ceil(popcount(data_in)/M)) when ready_out is held high.
- Throughput: one beat per cycle. With back-to-back masks there are no idle cycles between them.
- Combinational path ready_out -> ready_in exists, active on the last beat only. There is no combinational path from data_in or valid_in to any output.
- Lane selection is an M-deep cascade of priority picks over pend (each pick masks out the previous ones). Set M to meet timing.

## Test plan
- Reset, basic drain: N=8, M=1, REVERSE=0, ready_out=1, accept 8'b1010_0110. Beats in cycles 1,2,3,4 carry index 1, 2, 5, 7. last_out is set only on index 7. ready_in returns to 1 in cycle 4.
- Multi-lane, reverse: N=8, M=3, REVERSE=1, accept 8'b1011_0101. Beat 1: indices 7, 5, 4, count 3, last 0. Beat 2: indices 2, 0, lane_mask 3'b011, count 2, last 1.
- Zero mask and full mask: N=4, M=2. Accept 0 -> one beat, lane_mask 0, last 1. Accept 4'hF -> beats {0,1} then {2,3}, last on the 2nd beat.
- Backpressure: N=8, M=2, mask 8'hFF, ready_out toggling 1,0,0,1. Outputs hold stable on stall cycles. Indices {0,1},{2,3},{4,5},{6,7} are each emitted exactly once and none is skipped.
- Back-to-back: M=1. Mask A = 8'h81 is accepted; mask B = 8'h10 is offered continuously. B is accepted in the same cycle that A's last beat (index 7) completes. The next cycle shows index 4, last 1, with no bubble.
- Reset mid-drain: N=16, M=1, mask 16'hFFFF. Assert reset after 3 beats. The next cycle shows valid_out 0, ready_in 1. A fresh mask 16'h0002 then yields a single beat with index 1.
